// File: rtl/ring_osc_freq_counter.sv
// Gated edge counter for a ring oscillator: enables the chain, lets it settle, counts rising edges.
// Optional macro RO_CNT_SATURATE_EN: saturate the edge counter instead of wrapping.
module ring_osc_freq_counter #(
  parameter int SETTLE_CYCLES = 8,
  parameter int GATE_CYCLES   = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_COUNT  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);

  logic [1:0]       state_reg;
  logic [TW-1:0]    timer_reg;
  logic             s1_reg, s2_reg, s3_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             osc_en_reg, busy_reg, done_reg;

  logic             edge_det;
  logic             cnt_full;
  logic             inc;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  assign edge_det = s2_reg & ~s3_reg;
  assign cnt_full = &cnt_reg;
  assign inc      = edge_det && (state_reg == S_COUNT);

`ifdef RO_CNT_SATURATE_EN
  assign cnt_inc = cnt_full ? cnt_reg : cnt_reg + 1'b1;
`else
  assign cnt_inc = cnt_reg + 1'b1;
`endif

  assign cnt_next = inc ? cnt_inc : cnt_reg;
  assign ovf_next = ovf_reg | (inc & cnt_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      s3_reg       <= 1'b0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      osc_en_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      s1_reg <= osc_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg  <= S_WARMUP;
            timer_reg  <= SETTLE_LOAD;
            cnt_reg    <= '0;
            ovf_reg    <= 1'b0;
            osc_en_reg <= 1'b1;
            busy_reg   <= 1'b1;
          end
        end
        S_WARMUP: begin
          if (timer_reg == '0) begin
            state_reg <= S_COUNT;
            timer_reg <= GATE_LOAD;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        S_COUNT: begin
          cnt_reg <= cnt_next;
          ovf_reg <= ovf_next;
          // last gate cycle: its edge is folded into the published result
          if (timer_reg == '0) begin
            state_reg    <= S_DONE;
            timer_reg    <= '0;
            count_reg    <= cnt_next;
            overflow_reg <= ovf_next;
            done_reg     <= 1'b1;
            osc_en_reg   <= 1'b0;
            busy_reg     <= 1'b0;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          timer_reg <= '0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign osc_en   = osc_en_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule
